mem_access_ctrl: RTL

Bus-side controller directly upstream of memory_unit. It accepts one load/store request at a time from the CPU control unit and drives memory_unit's Enable/ReadWrite/Address/DataIn/wordSelector pins. It completes the MFC handshake and returns read data, zero- or sign-extended, for loading into MDR/IR. It also rejects misaligned or illegal-size accesses and flags a memory timeout.

---
 rtl/mem_pkg.sv | 45 ++++
 rtl/mem_access_ctrl_if.sv | 37 +++
 rtl/load_extend.sv | 23 ++
 rtl/mem_access_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access path: size, direction and
// error codes, controller state encoding and the alignment check.
package mem_pkg;

    // Access size codes, identical to memory_unit's wordSelector encoding
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // ReadWrite pin polarity
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Response error codes
    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_SIZE     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACCESS  = 2'b01,
        ST_DONE    = 2'b10,
        ST_RELEASE = 2'b11
    } state_e;

    // Classify a request before memory is touched; illegal size wins
    // over misalignment.
    function automatic logic [1:0] check_access(input logic [1:0] size,
                                                input logic [1:0] addr_lo);
        logic [1:0] err;
        if (size == SZ_ILL) begin
            err = ERR_SIZE;
        end else if ((size == SZ_HALF) && (addr_lo[0] != 1'b0)) begin
            err = ERR_MISALIGN;
        end else if ((size == SZ_WORD) && (addr_lo != 2'b00)) begin
            err = ERR_MISALIGN;
        end else begin
            err = ERR_OK;
        end
        return err;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response channel from the CPU control unit plus the
// memory_unit pin bundle, as seen by mem_access_ctrl.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_enable;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [1:0]  mem_wsel;
    logic        mem_mfc;
    logic [31:0] mem_dout;

    // Controller side
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_mfc, mem_dout,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_enable, mem_rw, mem_addr, mem_din, mem_wsel
    );

    // Requester / memory side
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_mfc, mem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_enable, mem_rw, mem_addr, mem_din, mem_wsel
    );
endinterface

// File: rtl/load_extend.sv
// Zero/sign extension of right-justified load data by access size.
// Purely combinational so the writeback stage can reuse it.
module load_extend
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] raw,
    output logic [31:0] result
);

    // Select the live bits and replicate the sign bit when requested
    always_comb begin
        result = raw;
        case (size)
            SZ_BYTE: result = {{24{is_signed & raw[7]}}, raw[7:0]};
            SZ_HALF: result = {{16{is_signed & raw[15]}}, raw[15:0]};
            SZ_WORD: result = raw;
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller in front of memory_unit.
// Checks the request, drives Enable/ReadWrite/Address/DataIn/wordSelector,
// waits for MFC (bounded by a timeout), returns extended read data and
// holds off the next request until MFC has dropped again.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [1:0]       size_r, size_nxt_s;
    logic             signed_r, signed_nxt_s;
    logic             write_r, write_nxt_s;

    logic             req_ready_r, req_ready_nxt_s;
    logic             resp_valid_r, resp_valid_nxt_s;
    logic [31:0]      resp_rdata_r, resp_rdata_nxt_s;
    logic [1:0]       resp_err_r, resp_err_nxt_s;
    logic             mem_enable_r, mem_enable_nxt_s;
    logic             mem_rw_r, mem_rw_nxt_s;
    logic [31:0]      mem_addr_r, mem_addr_nxt_s;
    logic [31:0]      mem_din_r, mem_din_nxt_s;
    logic [1:0]       mem_wsel_r, mem_wsel_nxt_s;

    logic [1:0]       chk_err_s;
    logic             timeout_s;
    logic [31:0]      ext_data_s;

    assign chk_err_s = check_access(bus.req_size, bus.req_addr[1:0]);
    assign timeout_s = (cnt_r == CNT_LAST);

    load_extend u_load_extend (
        .size      (size_r),
        .is_signed (signed_r),
        .raw       (bus.mem_dout),
        .result    (ext_data_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; MFC beats timeout, DONE waits out a lingering MFC
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_nxt_s = (chk_err_s == ERR_OK) ? ST_ACCESS : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (bus.mem_mfc || timeout_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_DONE:    state_nxt_s = bus.mem_mfc ? ST_RELEASE : ST_IDLE;
            ST_RELEASE: state_nxt_s = bus.mem_mfc ? ST_RELEASE : ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and request capture
    always_comb begin
        cnt_nxt_s        = cnt_r;
        size_nxt_s       = size_r;
        signed_nxt_s     = signed_r;
        write_nxt_s      = write_r;
        resp_rdata_nxt_s = resp_rdata_r;
        resp_err_nxt_s   = resp_err_r;
        mem_rw_nxt_s     = mem_rw_r;
        mem_addr_nxt_s   = mem_addr_r;
        mem_din_nxt_s    = mem_din_r;
        mem_wsel_nxt_s   = mem_wsel_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    size_nxt_s   = bus.req_size;
                    signed_nxt_s = bus.req_signed;
                    write_nxt_s  = bus.req_write;
                    cnt_nxt_s    = '0;
                    if (chk_err_s != ERR_OK) begin
                        // Rejected: memory pins are left untouched
                        resp_err_nxt_s   = chk_err_s;
                        resp_rdata_nxt_s = 32'h0000_0000;
                    end else begin
                        mem_addr_nxt_s = bus.req_addr;
                        mem_din_nxt_s  = bus.req_wdata;
                        mem_wsel_nxt_s = bus.req_size;
                        mem_rw_nxt_s   = bus.req_write ? RW_WRITE : RW_READ;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_ACCESS: begin
                cnt_nxt_s = cnt_r + CNT_ONE;
                if (bus.mem_mfc) begin
                    resp_err_nxt_s   = ERR_OK;
                    resp_rdata_nxt_s = write_r ? 32'h0000_0000 : ext_data_s;
                end else if (timeout_s) begin
                    resp_err_nxt_s   = ERR_TIMEOUT;
                    resp_rdata_nxt_s = 32'h0000_0000;
                end else begin
                    resp_err_nxt_s   = resp_err_r;
                end
            end
            default: begin
                cnt_nxt_s = cnt_r;
            end
        endcase
        mem_enable_nxt_s = (state_nxt_s == ST_ACCESS);
        req_ready_nxt_s  = (state_nxt_s == ST_IDLE);
        resp_valid_nxt_s = (state_nxt_s == ST_DONE);
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r        <= '0;
            size_r       <= SZ_WORD;
            signed_r     <= 1'b0;
            write_r      <= 1'b0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= ERR_OK;
            mem_enable_r <= 1'b0;
            mem_rw_r     <= RW_READ;
            mem_addr_r   <= 32'h0000_0000;
            mem_din_r    <= 32'h0000_0000;
            mem_wsel_r   <= SZ_WORD;
        end else begin
            cnt_r        <= cnt_nxt_s;
            size_r       <= size_nxt_s;
            signed_r     <= signed_nxt_s;
            write_r      <= write_nxt_s;
            req_ready_r  <= req_ready_nxt_s;
            resp_valid_r <= resp_valid_nxt_s;
            resp_rdata_r <= resp_rdata_nxt_s;
            resp_err_r   <= resp_err_nxt_s;
            mem_enable_r <= mem_enable_nxt_s;
            mem_rw_r     <= mem_rw_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_din_r    <= mem_din_nxt_s;
            mem_wsel_r   <= mem_wsel_nxt_s;
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.mem_enable = mem_enable_r;
    assign bus.mem_rw     = mem_rw_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_din    = mem_din_r;
    assign bus.mem_wsel   = mem_wsel_r;

endmodule
